// File: rtl/ddr3_cmd_arbiter_pkg.sv
// Shared DDR3 command codes, owner encodings and small helpers for the
// command arbiter and its owner FIFO.
package ddr3_cmd_arbiter_pkg;

    // {RAS#, CAS#, WE#} command encodings
    localparam logic [2:0] CMD_MRS  = 3'b000;
    localparam logic [2:0] CMD_REFR = 3'b001;
    localparam logic [2:0] CMD_PREC = 3'b010;
    localparam logic [2:0] CMD_ACTV = 3'b011;
    localparam logic [2:0] CMD_WRIT = 3'b100;
    localparam logic [2:0] CMD_READ = 3'b101;
    localparam logic [2:0] CMD_ZQCL = 3'b110;
    localparam logic [2:0] CMD_NOOP = 3'b111;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic       req;
        logic       seq;
        logic [2:0] cmd;
        logic [2:0] ba;
    } cmd_hdr_t;

    function automatic logic [3:0] run_inc(input logic [3:0] cur, input logic [3:0] cap);
        return (cur >= cap) ? cap : cur + 4'd1;
    endfunction

endpackage

// File: rtl/ddr3_owner_fifo.sv
// 1-bit owner FIFO: remembers which requester issued each outstanding READ
// so returned bursts can be steered back in issue order.
module ddr3_owner_fifo
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    // A full FIFO refuses a push even when a pop frees a slot this cycle
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign head   = r_mem[r_rp];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= din;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Shares the DDL command port and read-data path between fast-path reader A
// and controller B; grants hold for a whole command sequence.
module ddr3_cmd_arbiter
    import ddr3_cmd_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DDR_ROW_BITS = 13,
    parameter int MAX_A_RUN    = 4,
    parameter int OWN_DEPTH    = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ddl_run_i,
    input  logic                    ddl_ref_i,
    input  logic                    ddl_rdy_i,
    output logic                    ddl_req_o,
    output logic                    ddl_seq_o,
    output logic [2:0]              ddl_cmd_o,
    output logic [2:0]              ddl_ba_o,
    output logic [DDR_ROW_BITS-1:0] ddl_adr_o,
    input  logic                    a_req_i,
    input  logic                    a_seq_i,
    input  logic [2:0]              a_cmd_i,
    input  logic [2:0]              a_ba_i,
    input  logic [DDR_ROW_BITS-1:0] a_adr_i,
    output logic                    a_rdy_o,
    output logic                    a_ref_o,
    input  logic                    b_req_i,
    input  logic                    b_seq_i,
    input  logic [2:0]              b_cmd_i,
    input  logic [2:0]              b_ba_i,
    input  logic [DDR_ROW_BITS-1:0] b_adr_i,
    output logic                    b_rdy_o,
    output logic                    b_ref_o,
    input  logic                    ddl_rvalid_i,
    input  logic                    ddl_rlast_i,
    input  logic [WIDTH-1:0]        ddl_rdata_i,
    output logic                    ddl_rready_o,
    output logic                    a_rvalid_o,
    output logic                    a_rlast_o,
    output logic [WIDTH-1:0]        a_rdata_o,
    input  logic                    a_rready_i,
    output logic                    b_rvalid_o,
    output logic                    b_rlast_o,
    output logic [WIDTH-1:0]        b_rdata_o,
    input  logic                    b_rready_i,
    output logic                    err_o
);
    arb_state_e r_state, w_state_nxt;
    logic [3:0] r_arun, w_arun_nxt;
    logic       r_live, r_run_q, r_err;

    logic       w_win_a, w_sel_a, w_a_stall, w_b_stall, w_stall;
    logic       w_xfer, w_end, w_run_fall;
    logic       w_full, w_empty, w_head, w_push, w_pop, w_head_a, w_head_b;
    cmd_hdr_t   w_a_hdr, w_b_hdr, w_sel;

    assign w_a_hdr = '{req: a_req_i, seq: a_seq_i, cmd: a_cmd_i, ba: a_ba_i};
    assign w_b_hdr = '{req: b_req_i, seq: b_seq_i, cmd: b_cmd_i, ba: b_ba_i};

    // A is masked during refresh/init and when it has used its run budget
    assign w_win_a = a_req_i & ddl_run_i & ~ddl_ref_i
                   & ~((r_arun == 4'(MAX_A_RUN)) & b_req_i);
    assign w_sel_a = (r_state == ST_OWN_A) | ((r_state == ST_IDLE) & w_win_a);
    assign w_sel   = w_sel_a ? w_a_hdr : w_b_hdr;

    assign w_a_stall = (a_cmd_i == CMD_READ) & w_full;
    assign w_b_stall = (b_cmd_i == CMD_READ) & w_full;
    assign w_stall   = w_sel_a ? w_a_stall : w_b_stall;

    // r_live keeps every request/accept low while reset is asserted
    assign ddl_req_o = r_live & w_sel.req & ~w_stall;
    assign ddl_seq_o = w_sel.seq;
    assign ddl_cmd_o = ddl_req_o ? w_sel.cmd : CMD_NOOP;
    assign ddl_ba_o  = w_sel.ba;
    assign ddl_adr_o = w_sel_a ? a_adr_i : b_adr_i;

    assign a_rdy_o = r_live &  w_sel_a & ddl_rdy_i & ~w_a_stall;
    assign b_rdy_o = r_live & ~w_sel_a & ddl_rdy_i & ~w_b_stall;
    assign a_ref_o = ddl_ref_i;
    assign b_ref_o = ddl_ref_i;

    assign w_xfer     = ddl_req_o & ddl_rdy_i;
    assign w_end      = w_xfer & ~w_sel.seq;
    assign w_run_fall = r_run_q & ~ddl_run_i;

    always_comb begin
        w_state_nxt = r_state;
        w_arun_nxt  = r_arun;
        case (r_state)
            ST_IDLE:  if (r_live & w_sel.req & ~w_end)
                          w_state_nxt = w_sel_a ? ST_OWN_A : ST_OWN_B;
            ST_OWN_A,
            ST_OWN_B: if (w_end) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_end)
            w_arun_nxt = (w_sel_a & b_req_i) ? run_inc(r_arun, 4'(MAX_A_RUN)) : 4'd0;
        if (w_run_fall) begin
            w_state_nxt = ST_IDLE;
            w_arun_nxt  = 4'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_arun  <= 4'd0;
            r_live  <= 1'b0;
            r_run_q <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_arun  <= w_arun_nxt;
            r_live  <= 1'b1;
            r_run_q <= ddl_run_i;
            if (ddl_rvalid_i & w_empty)
                r_err <= 1'b1;
        end
    end

    assign w_push = w_xfer & (w_sel.cmd == CMD_READ);

    ddr3_owner_fifo #(.DEPTH(OWN_DEPTH)) u_own_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (w_push),
        .din     (w_sel_a ? OWN_A : OWN_B),
        .pop     (w_pop),
        .full    (w_full),
        .empty   (w_empty),
        .head    (w_head)
    );

    // With nothing outstanding, stray beats are drained rather than stalled
    assign w_head_a     = ~w_empty & (w_head == OWN_A);
    assign w_head_b     = ~w_empty & (w_head == OWN_B);
    assign ddl_rready_o = w_empty | (w_head_a & a_rready_i) | (w_head_b & b_rready_i);
    assign w_pop        = ddl_rvalid_i & ddl_rready_o & ddl_rlast_i & ~w_empty;

    assign a_rvalid_o = ddl_rvalid_i & w_head_a;
    assign b_rvalid_o = ddl_rvalid_i & w_head_b;
    assign a_rlast_o  = a_rvalid_o & ddl_rlast_i;
    assign b_rlast_o  = b_rvalid_o & ddl_rlast_i;
    assign a_rdata_o  = ddl_rdata_i;
    assign b_rdata_o  = ddl_rdata_i;
    assign err_o      = r_err;

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Bench for ddr3_cmd_arbiter: table vectors, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_ddr3_cmd_arbiter;
    import ddr3_cmd_arbiter_pkg::*;

    localparam int WIDTH = 32, ROWB = 13, MAXR = 4, DEPTH = 4;

    logic clock, reset_n;
    logic ddl_run_i, ddl_ref_i, ddl_rdy_i, ddl_req_o, ddl_seq_o;
    logic [2:0] ddl_cmd_o, ddl_ba_o;
    logic [ROWB-1:0] ddl_adr_o;
    logic a_req_i, a_seq_i, a_rdy_o, a_ref_o;
    logic [2:0] a_cmd_i, a_ba_i;
    logic [ROWB-1:0] a_adr_i;
    logic b_req_i, b_seq_i, b_rdy_o, b_ref_o;
    logic [2:0] b_cmd_i, b_ba_i;
    logic [ROWB-1:0] b_adr_i;
    logic ddl_rvalid_i, ddl_rlast_i, ddl_rready_o;
    logic [WIDTH-1:0] ddl_rdata_i, a_rdata_o, b_rdata_o;
    logic a_rvalid_o, a_rlast_o, a_rready_i, b_rvalid_o, b_rlast_o, b_rready_i, err_o;

    ddr3_cmd_arbiter #(.WIDTH(WIDTH), .DDR_ROW_BITS(ROWB), .MAX_A_RUN(MAXR), .OWN_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .ddl_run_i(ddl_run_i), .ddl_ref_i(ddl_ref_i),
        .ddl_rdy_i(ddl_rdy_i), .ddl_req_o(ddl_req_o), .ddl_seq_o(ddl_seq_o),
        .ddl_cmd_o(ddl_cmd_o), .ddl_ba_o(ddl_ba_o), .ddl_adr_o(ddl_adr_o),
        .a_req_i(a_req_i), .a_seq_i(a_seq_i), .a_cmd_i(a_cmd_i), .a_ba_i(a_ba_i),
        .a_adr_i(a_adr_i), .a_rdy_o(a_rdy_o), .a_ref_o(a_ref_o),
        .b_req_i(b_req_i), .b_seq_i(b_seq_i), .b_cmd_i(b_cmd_i), .b_ba_i(b_ba_i),
        .b_adr_i(b_adr_i), .b_rdy_o(b_rdy_o), .b_ref_o(b_ref_o),
        .ddl_rvalid_i(ddl_rvalid_i), .ddl_rlast_i(ddl_rlast_i), .ddl_rdata_i(ddl_rdata_i),
        .ddl_rready_o(ddl_rready_o), .a_rvalid_o(a_rvalid_o), .a_rlast_o(a_rlast_o),
        .a_rdata_o(a_rdata_o), .a_rready_i(a_rready_i), .b_rvalid_o(b_rvalid_o),
        .b_rlast_o(b_rlast_o), .b_rdata_o(b_rdata_o), .b_rready_i(b_rready_i), .err_o(err_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic run, ref_, rdy;
        logic a_req, a_seq; logic [2:0] a_cmd;
        logic b_req, b_seq; logic [2:0] b_cmd;
        logic rvalid, rlast, a_rready, b_rready;
    } in_t;

    typedef struct {
        in_t i;
        logic req; logic [2:0] cmd;
        logic ardy, brdy, arv, brv, rready;
    } vec_t;

    int n_cmp = 0, n_bad = 0;

    // reference model: owner as 0 none / 1 A / 2 B, outstanding reads as a queue
    int   m_own, m_arun;
    bit   m_q[$];
    bit   m_err, m_live, m_run_q;
    bit   e_selA, e_req, e_seq, e_rready, e_empty;
    logic [2:0] e_scmd;
    bit   end_log[$];
    bit   pop_log[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v.run = 1; v.ref_ = 0; v.rdy = 1;
        v.a_req = 0; v.a_seq = 0; v.a_cmd = CMD_NOOP;
        v.b_req = 0; v.b_seq = 0; v.b_cmd = CMD_NOOP;
        v.rvalid = 0; v.rlast = 0; v.a_rready = 1; v.b_rready = 1;
        return v;
    endfunction

    function automatic logic [2:0] rcmd();
        case ($urandom_range(0, 3))
            0: return CMD_READ;
            1: return CMD_ACTV;
            2: return CMD_PREC;
            default: return CMD_REFR;
        endcase
    endfunction

    task automatic model_reset();
        m_own = 0; m_arun = 0; m_q.delete(); m_err = 0; m_live = 0; m_run_q = 0;
    endtask

    task automatic apply(input in_t v);
        ddl_run_i = v.run; ddl_ref_i = v.ref_; ddl_rdy_i = v.rdy;
        a_req_i = v.a_req; a_seq_i = v.a_seq; a_cmd_i = v.a_cmd;
        b_req_i = v.b_req; b_seq_i = v.b_seq; b_cmd_i = v.b_cmd;
        ddl_rvalid_i = v.rvalid; ddl_rlast_i = v.rlast;
        a_rready_i = v.a_rready; b_rready_i = v.b_rready;
        ddl_rdata_i = $urandom;
        #1;
    endtask

    task automatic check_model();
        logic [2:0] s_ba; logic [ROWB-1:0] s_adr; logic s_req;
        bit full, hA, hB, ardy, brdy;
        if (m_own == 1) e_selA = 1;
        else if (m_own == 2) e_selA = 0;
        else e_selA = ddl_run_i && !ddl_ref_i && a_req_i && !(m_arun == MAXR && b_req_i);
        s_req  = e_selA ? a_req_i : b_req_i;
        e_seq  = e_selA ? a_seq_i : b_seq_i;
        e_scmd = e_selA ? a_cmd_i : b_cmd_i;
        s_ba   = e_selA ? a_ba_i  : b_ba_i;
        s_adr  = e_selA ? a_adr_i : b_adr_i;
        full    = (m_q.size() == DEPTH);
        e_empty = (m_q.size() == 0);
        hA = 0; hB = 0;
        if (!e_empty) begin hA = (m_q[0] == 1'b0); hB = (m_q[0] == 1'b1); end
        e_req = m_live && s_req && !(e_scmd == CMD_READ && full);
        ardy  = m_live &&  e_selA && ddl_rdy_i && !(a_cmd_i == CMD_READ && full);
        brdy  = m_live && !e_selA && ddl_rdy_i && !(b_cmd_i == CMD_READ && full);
        e_rready = e_empty ? 1'b1 : (hA ? a_rready_i : b_rready_i);
        chk("ddl_cmd", {ddl_req_o, ddl_seq_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o},
            {e_req, e_seq, (e_req ? e_scmd : CMD_NOOP), s_ba, s_adr});
        chk("rdy_ref", {a_rdy_o, b_rdy_o, a_ref_o, b_ref_o}, {ardy, brdy, ddl_ref_i, ddl_ref_i});
        chk("rd_route", {a_rvalid_o, b_rvalid_o, a_rlast_o, b_rlast_o, ddl_rready_o},
            {ddl_rvalid_i && hA, ddl_rvalid_i && hB, ddl_rvalid_i && hA && ddl_rlast_i,
             ddl_rvalid_i && hB && ddl_rlast_i, e_rready});
        if (ddl_rvalid_i && hA) chk("a_rdata", a_rdata_o, ddl_rdata_i);
        if (ddl_rvalid_i && hB) chk("b_rdata", b_rdata_o, ddl_rdata_i);
        chk("err", err_o, m_err);
    endtask

    task automatic advance();
        bit xfer;
        @(posedge clock);
        xfer = e_req && ddl_rdy_i;
        if (ddl_rvalid_i && e_rready && ddl_rlast_i && !e_empty) pop_log.push_back(m_q.pop_front());
        if (xfer && e_scmd == CMD_READ) m_q.push_back(e_selA ? 1'b0 : 1'b1);
        if (ddl_rvalid_i && e_empty) m_err = 1;
        if (m_run_q && !ddl_run_i) begin
            m_own = 0; m_arun = 0;
        end else if (xfer && !e_seq) begin
            end_log.push_back(e_selA);
            m_own  = 0;
            m_arun = (e_selA && b_req_i) ? ((m_arun + 1 > MAXR) ? MAXR : m_arun + 1) : 0;
        end else if (m_own == 0 && m_live && (e_selA ? a_req_i : b_req_i)) begin
            m_own = e_selA ? 1 : 2;
        end
        m_run_q = ddl_run_i;
        m_live  = 1;
        #1;
    endtask

    task automatic step(input in_t v);
        apply(v);
        check_model();
        advance();
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_cmd"}, {ddl_req_o, ddl_cmd_o}, {1'b0, CMD_NOOP});
        chk({nm, "_rdy"}, {a_rdy_o, b_rdy_o}, 2'b00);
        chk({nm, "_rvalid"}, {a_rvalid_o, b_rvalid_o}, 2'b00);
        chk({nm, "_err"}, err_o, 1'b0);
    endtask

    vec_t tbl[12];
    in_t  v;
    logic [9:0] got_order;
    logic [2:0] got_pops;

    initial begin
        // single A sequence: ACT(seq) then RD, 8 beats routed to A, FIFO drains
        tbl[0].i = idle();
        tbl[0].req = 0; tbl[0].cmd = CMD_NOOP; tbl[0].ardy = 0; tbl[0].brdy = 1;
        tbl[0].arv = 0; tbl[0].brv = 0; tbl[0].rready = 1;
        tbl[1] = tbl[0];
        tbl[1].i.a_req = 1; tbl[1].i.a_seq = 1; tbl[1].i.a_cmd = CMD_ACTV;
        tbl[1].req = 1; tbl[1].cmd = CMD_ACTV; tbl[1].ardy = 1; tbl[1].brdy = 0;
        tbl[2] = tbl[1];
        tbl[2].i.a_seq = 0; tbl[2].i.a_cmd = CMD_READ; tbl[2].cmd = CMD_READ;
        for (int k = 3; k <= 10; k++) begin
            tbl[k] = tbl[0];
            tbl[k].i.rvalid = 1; tbl[k].i.rlast = (k == 10);
            tbl[k].i.a_rready = 1; tbl[k].i.b_rready = 0;
            tbl[k].arv = 1;
        end
        tbl[11] = tbl[0];
        tbl[11].i.a_rready = 0; tbl[11].i.b_rready = 0;

        a_ba_i = 3'd1; a_adr_i = 13'h0A0A; b_ba_i = 3'd2; b_adr_i = 13'h0B0B;
        model_reset();
        reset_n = 0;
        v = idle(); v.a_req = 1; v.b_req = 1; v.b_cmd = CMD_REFR; v.rvalid = 1;
        apply(v);
        #20;
        chk_reset("reset");
        @(posedge clock); #1;
        reset_n = 1;
        step(idle());
        step(idle());

        for (int k = 0; k < 12; k++) begin
            apply(tbl[k].i);
            chk($sformatf("tbl%0d", k),
                {ddl_req_o, ddl_cmd_o, a_rdy_o, b_rdy_o, a_rvalid_o, b_rvalid_o, ddl_rready_o},
                {tbl[k].req, tbl[k].cmd, tbl[k].ardy, tbl[k].brdy, tbl[k].arv, tbl[k].brv, tbl[k].rready});
            check_model();
            advance();
        end

        // contention: starvation cap gives B one sequence after four of A
        end_log.delete();
        v = idle(); v.a_req = 1; v.b_req = 1; v.a_cmd = CMD_ACTV; v.b_cmd = CMD_ACTV;
        for (int k = 0; k < 10; k++) begin
            apply(v);
            got_order[9-k] = a_rdy_o;
            check_model();
            advance();
        end
        chk("grant_order", got_order, 10'b1111011110);

        // refresh masks A; A wins as soon as ddl_ref_i is low
        v = idle(); v.ref_ = 1; v.a_req = 1; v.a_cmd = CMD_ACTV; v.b_req = 1; v.b_cmd = CMD_REFR;
        for (int k = 0; k < 3; k++) begin
            apply(v);
            chk("ref_a_masked", {a_rdy_o, b_rdy_o, ddl_cmd_o}, {1'b0, 1'b1, CMD_REFR});
            check_model();
            advance();
        end
        v.ref_ = 0; v.b_req = 0;
        apply(v);
        chk("ref_a_after", {a_rdy_o, ddl_cmd_o}, {1'b1, CMD_ACTV});
        check_model();
        advance();

        // FIFO full: fifth B READ stalls until the first pop
        v = idle(); v.b_req = 1; v.b_cmd = CMD_READ;
        for (int k = 0; k < 4; k++) step(v);
        for (int k = 0; k < 2; k++) begin
            apply(v);
            chk("full_stall", {b_rdy_o, ddl_req_o}, 2'b00);
            check_model();
            advance();
        end
        v.rvalid = 1; v.rlast = 1;
        apply(v);
        chk("full_pop_cycle", b_rdy_o, 1'b0);
        check_model();
        advance();
        v.rvalid = 0; v.rlast = 0;
        apply(v);
        chk("full_accept", {b_rdy_o, ddl_req_o}, 2'b11);
        check_model();
        advance();
        v = idle(); v.rvalid = 1; v.rlast = 1;
        for (int k = 0; k < 4; k++) step(v);

        // routing: READs A,B,A with A stalled; B waits behind A
        v = idle(); v.a_req = 1; v.a_cmd = CMD_READ; step(v);
        v = idle(); v.b_req = 1; v.b_cmd = CMD_READ; step(v);
        v = idle(); v.a_req = 1; v.a_cmd = CMD_READ; step(v);
        pop_log.delete();
        v = idle(); v.rvalid = 1; v.rlast = 1; v.a_rready = 0;
        for (int k = 0; k < 3; k++) begin
            apply(v);
            chk("route_a_stall", {a_rvalid_o, b_rvalid_o, ddl_rready_o}, 3'b100);
            check_model();
            advance();
        end
        v.a_rready = 1;
        for (int k = 0; k < 3; k++) step(v);
        got_pops = 3'b111;
        for (int k = 0; k < 3 && k < pop_log.size(); k++) got_pops[2-k] = pop_log[k];
        chk("route_order", got_pops, 3'b010);

        // stray data with empty FIFO sets a sticky error
        v = idle(); v.rvalid = 1; v.rlast = 1;
        step(v);
        chk("err_set", err_o, 1'b1);
        step(idle());
        step(idle());
        chk("err_sticky", err_o, 1'b1);

        // async reset while A owns the port
        v = idle(); v.a_req = 1; v.a_seq = 1; v.a_cmd = CMD_ACTV;
        step(v);
        apply(v);
        reset_n = 0;
        #1;
        chk_reset("rst_mid");
        model_reset();
        @(posedge clock); #1;
        reset_n = 1;
        step(idle());

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            v.run = ($urandom_range(0, 99) < 97);
            v.ref_ = ($urandom_range(0, 99) < 15);
            v.rdy = ($urandom_range(0, 99) < 75);
            v.a_req = $urandom_range(0, 1); v.a_seq = ($urandom_range(0, 9) < 4); v.a_cmd = rcmd();
            v.b_req = $urandom_range(0, 1); v.b_seq = ($urandom_range(0, 9) < 4); v.b_cmd = rcmd();
            v.rvalid = ($urandom_range(0, 9) < 4); v.rlast = ($urandom_range(0, 9) < 4);
            v.a_rready = ($urandom_range(0, 9) < 7); v.b_rready = ($urandom_range(0, 9) < 7);
            a_ba_i = 3'($urandom); b_ba_i = 3'($urandom);
            a_adr_i = ROWB'($urandom); b_adr_i = ROWB'($urandom);
            step(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr3_cmd_arbiter.md
# ddr3_cmd_arbiter

Shares the single DDL command port and READ data-path between two requesters: port A (low-latency fast-path reads) and port B (the main memory controller). Each grant holds for one whole command sequence (e.g. ACT→RD, or PRE→ACT→RD). Arbitration is priority-based with a starvation cap. A small owner FIFO routes each returned READ burst back to the requester that issued it. The block sits between both command sources and the DDL, and replaces ad-hoc interception of controller signals.

## Interface
- `WIDTH`, 32, read-data width.
- `DDR_ROW_BITS`, 13, DDL address width.
- `MAX_A_RUN`, 4, max consecutive A sequences granted while B waits; range 1..15.
- `OWN_DEPTH`, 4, owner-FIFO depth (outstanding READs); power of two, ≥2.

Ports:
- `clock` in 1 — single clock.
- `reset_n` in 1 — asynchronous, active-low reset.
- `ddl_run_i` in 1 — DDL initialisation complete.
- `ddl_ref_i` in 1 — refresh pending.
- `ddl_rdy_i` in 1 — DDL accepts the command this cycle.
- `ddl_req_o`, `ddl_seq_o` out 1 — command request and sequence-continues flag to the DDL.
- `ddl_cmd_o` out 3, `ddl_ba_o` out 3, `ddl_adr_o` out DDR_ROW_BITS — command, bank and address to the DDL.
- `a_req_i`, `a_seq_i` in 1; `a_cmd_i` in 3; `a_ba_i` in 3; `a_adr_i` in DDR_ROW_BITS — requester A command.
- `a_rdy_o`, `a_ref_o` out 1 — A accept and refresh-pending indications.
- `b_req_i`, `b_seq_i`, `b_cmd_i`, `b_ba_i`, `b_adr_i`, `b_rdy_o`, `b_ref_o` — same as A, for requester B.
- `ddl_rvalid_i`, `ddl_rlast_i` in 1; `ddl_rdata_i` in WIDTH; `ddl_rready_o` out 1 — DDL read data.
- `a_rvalid_o`, `a_rlast_o` out 1; `a_rdata_o` out WIDTH; `a_rready_i` in 1 — A read data. B has the same set (`b_rvalid_o`, `b_rlast_o`, `b_rdata_o`, `b_rready_i`).
- `err_o` out 1 — sticky protocol error.

## Operation
- A command *transfer* occurs when `ddl_req_o & ddl_rdy_i`.
- States:
  - IDLE.
  - OWN_A: A owns the port.
  - OWN_B: B owns the port.
- In IDLE the winner is forwarded combinationally to `ddl_*` (zero added latency).
- Winner selection:
  - B wins if `!ddl_run_i`, or A is masked, or `a_run == MAX_A_RUN` with `b_req_i` high.
  - Otherwise A wins if `a_req_i` is high.
  - Otherwise B wins.
- A is masked in IDLE when `ddl_ref_i` or `!ddl_run_i` is high. B issues refresh and init commands.
- IDLE → OWN_x when the winner has req high and either there is no transfer, or there is a transfer with seq=1.
- IDLE stays IDLE on a transfer with seq=0.
- OWN_x → IDLE on a transfer with `x_seq_i`=0. While in OWN_x the other requester is ignored, including during refresh.
- `x_rdy_o = ddl_rdy_i` when x is selected (winner in IDLE, or owner), otherwise 0. Exception: forced 0 when `x_cmd_i == CMD_READ` and the owner FIFO is full.
- `ddl_req_o` is also blocked in that FIFO-full stall case.
- Non-selected requester: `ddl_*` ignores it and its rdy is 0.
- `a_ref_o = b_ref_o = ddl_ref_i`.
- `a_run` counter (4b):
  - +1 on each A sequence end (transfer with seq=0) when `b_req_i` is high.
  - Cleared on any B sequence end, or when `b_req_i` is low at an A sequence end.
  - Saturates at MAX_A_RUN.
- Owner FIFO:
  - Every transferred CMD_READ pushes its owner (0=A, 1=B).
  - Data beats route to the head owner: `x_rvalid_o = ddl_rvalid_i & (head==x) & !empty`.
  - `ddl_rready_o = x_rready_i` for the head owner.
  - Pop on `ddl_rvalid_i & ddl_rready_o & ddl_rlast_i`.
- Boundary conditions:
  - At full, a push is refused even if a pop happens in the same cycle.
  - A simultaneous push and pop below full keeps the count unchanged.
  - `ddl_rvalid_i` while the FIFO is empty: `ddl_rready_o=1` (data drained), no output valids, `err_o` set.
  - `ddl_run_i` falling: state → IDLE next cycle and `a_run` cleared. The FIFO is not cleared.

## Timing
- Reset (async, `reset_n`=0):
  - state IDLE, FIFO empty, `a_run`=0, `err_o`=0.
  - All `*_rvalid_o`, `*_rdy_o` and `ddl_req_o` are 0.
  - `ddl_cmd_o` = CMD_NOOP.
- Reset mid-sequence or mid-burst drops ownership and all outstanding owners. Later stray data sets `err_o`.
- Command path: combinational, 0 cycles. Ownership and counter updates are registered on the transfer edge.
- Read path: combinational, 0 cycles. FIFO count and head update on the edge after `rlast`.

## Structure
- Command codes (CMD_NOOP, CMD_READ, CMD_ACTV, CMD_PREC, CMD_REFR, …) come from the shared ddr3_settings include. Add owner encodings OWN_A/OWN_B there.
- Sub-module `ddr3_owner_fifo`: 1-bit-wide, OWN_DEPTH-deep, with push/pop/full/empty/head. All other logic is inline.

## Test plan
- A single sequence: A issues ACT(seq=1) then RD(seq=0), `ddl_rdy_i`=1, B idle → 2 transfers on consecutive cycles; 8 data beats appear on A only; FIFO returns to empty.
- Contention: A and B request continuously, MAX_A_RUN=4 → grant order of sequences is A,A,A,A,B,A,…; no interleaving inside a sequence.
- Refresh: `ddl_ref_i`=1 with A idle and A requesting → A never granted; B REF transfers; A granted the cycle after `ddl_ref_i` falls.
- FIFO full: 4 READs outstanding, 5th READ from B → `b_rdy_o`=0 until the first `rlast` pop, then accepted the following cycle.
- Routing: READ order A,B,A with A `rready` stalled 3 cycles → bursts delivered strictly in order; B data waits behind A.
- Errors and reset: data with FIFO empty → `err_o`=1 and stays 1. Async reset mid-OWN_A → all outputs at reset values immediately.
